exit_token_ctrl: RTL and testbench

Parametrised exit-side controller for the smart parking system: accepts an exit request carrying an encrypted token, decodes the slot number as `token ^ pattern`, validates it against an internal occupancy table and either grants (frees the slot) or denies the exit. The block keeps the occupancy bitmap and free-slot count, which are updated by entry events. After repeated invalid tokens it locks out further exit requests for a fixed time. It sits between the exit gate interface and the display/gate-actuator logic.

---
 rtl/parking_pkg.sv | 16 +
 rtl/slot_table.sv | 70 +++++++
 rtl/exit_token_ctrl.sv | 156 +++++++++++++++
 tb/tb_exit_token_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared types for the parking-system controllers: controller state encoding,
// default slot width and slot-index type.
package parking_pkg;

  localparam int unsigned DEF_SLOT_W = 3;

  typedef logic [DEF_SLOT_W-1:0] slot_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_RESP   = 2'd2,
    ST_LOCK   = 2'd3
  } state_e;

endpackage

// File: rtl/slot_table.sv
// Occupancy bitmap and free-slot counter. A set and a clear on the same slot
// in one cycle leave the slot occupied (set wins).
module slot_table
  import parking_pkg::*;
#(
  parameter int unsigned SLOT_W  = DEF_SLOT_W,
  parameter int unsigned N_SLOTS = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             set_valid_i,
  input  logic [SLOT_W-1:0]                set_slot_i,
  input  logic                             clr_valid_i,
  input  logic [SLOT_W-1:0]                clr_slot_i,
  output logic                             set_err_o,
  output logic [N_SLOTS-1:0]               occupancy_o,
  output logic [$clog2(N_SLOTS+1)-1:0]     free_count_o
);

  localparam int unsigned CNT_W = $clog2(N_SLOTS + 1);

  logic [N_SLOTS-1:0] occ_q, occ_d;
  logic [CNT_W-1:0]   free_q, free_d;
  logic               err_q, err_d;

  logic [N_SLOTS-1:0] set_mask, clr_mask;
  logic               set_in_range, clr_eff, same_slot, set_ok;

  always_comb begin
    set_mask     = '0;
    clr_mask     = '0;
    set_in_range = 1'b0;
    for (int unsigned i = 0; i < N_SLOTS; i++) begin
      if (set_slot_i == SLOT_W'(i)) begin
        set_mask[i]  = 1'b1;
        set_in_range = 1'b1;
      end
      if (clr_valid_i && (clr_slot_i == SLOT_W'(i))) clr_mask[i] = 1'b1;
    end
    clr_eff   = |clr_mask;
    // A slot being vacated this cycle counts as free for an arriving car
    same_slot = clr_eff && (clr_slot_i == set_slot_i);
    set_ok    = set_valid_i && set_in_range && (((occ_q & set_mask) == '0) || same_slot);
    err_d     = set_valid_i && !set_ok;
    occ_d     = (occ_q & ~clr_mask) | (set_ok ? set_mask : '0);
    free_d    = free_q;
    case ({clr_eff, set_ok})
      2'b10:   free_d = free_q + CNT_W'(1);
      2'b01:   free_d = free_q - CNT_W'(1);
      default: free_d = free_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q  <= '0;
      free_q <= CNT_W'(N_SLOTS);
      err_q  <= 1'b0;
    end else begin
      occ_q  <= occ_d;
      free_q <= free_d;
      err_q  <= err_d;
    end
  end

  assign occupancy_o  = occ_q;
  assign free_count_o = free_q;
  assign set_err_o    = err_q;

endmodule

// File: rtl/exit_token_ctrl.sv
// Exit-side parking controller: decodes slot = token ^ pattern, grants or
// denies the exit against the occupancy table. Lockout after repeated
// denials is built only when EXIT_FAIL_LOCK_EN is defined.
module exit_token_ctrl
  import parking_pkg::*;
#(
  parameter int unsigned SLOT_W      = DEF_SLOT_W,
  parameter int unsigned N_SLOTS     = 8,
  parameter int unsigned MAX_FAIL    = 3,
  parameter int unsigned LOCK_CYCLES = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         entry_valid,
  input  logic [SLOT_W-1:0]            entry_slot,
  output logic                         entry_err,
  input  logic                         exit_req,
  output logic                         exit_ready,
  input  logic [SLOT_W-1:0]            token,
  input  logic [SLOT_W-1:0]            pattern,
  output logic                         grant,
  output logic                         deny,
  output logic [SLOT_W-1:0]            park_number,
  output logic                         locked,
  output logic [N_SLOTS-1:0]           occupancy,
  output logic [$clog2(N_SLOTS+1)-1:0] free_count
);

  state_e             state_q;
  logic [SLOT_W-1:0]  token_q, pattern_q, park_q;
  logic               grant_q, deny_q, ready_q;
  logic [SLOT_W-1:0]  dec_slot;
  logic               slot_ok, clr_valid;

  assign dec_slot = token_q ^ pattern_q;

  always_comb begin
    slot_ok = 1'b0;
    for (int unsigned i = 0; i < N_SLOTS; i++) begin
      if ((dec_slot == SLOT_W'(i)) && occupancy[i]) slot_ok = 1'b1;
    end
  end

  // The slot is freed on the decode edge so the table is current while grant is high
  assign clr_valid = (state_q == ST_DECODE) && slot_ok;

  slot_table #(
    .SLOT_W  (SLOT_W),
    .N_SLOTS (N_SLOTS)
  ) u_slot_table (
    .clk          (clk),
    .rst          (rst),
    .set_valid_i  (entry_valid),
    .set_slot_i   (entry_slot),
    .clr_valid_i  (clr_valid),
    .clr_slot_i   (dec_slot),
    .set_err_o    (entry_err),
    .occupancy_o  (occupancy),
    .free_count_o (free_count)
  );

`ifdef EXIT_FAIL_LOCK_EN
  localparam int unsigned FAIL_W = $clog2(MAX_FAIL + 1);
  localparam int unsigned LOCK_W = $clog2(LOCK_CYCLES + 1);

  logic [FAIL_W-1:0] fail_q;
  logic [LOCK_W-1:0] timer_q;
  logic              locked_q;

  assign locked = locked_q;
`else
  assign locked = 1'b0;

  // Lockout parameters only matter with the feature built in
  if (MAX_FAIL == 0 || LOCK_CYCLES == 0) begin : g_lock_cfg_unused
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      token_q   <= '0;
      pattern_q <= '0;
      park_q    <= '0;
      grant_q   <= 1'b0;
      deny_q    <= 1'b0;
      ready_q   <= 1'b1;
`ifdef EXIT_FAIL_LOCK_EN
      fail_q    <= '0;
      timer_q   <= '0;
      locked_q  <= 1'b0;
`endif
    end else begin
      grant_q <= 1'b0;
      deny_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (exit_req && ready_q) begin
            token_q   <= token;
            pattern_q <= pattern;
            ready_q   <= 1'b0;
            state_q   <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          park_q  <= dec_slot;
          grant_q <= slot_ok;
          deny_q  <= !slot_ok;
`ifdef EXIT_FAIL_LOCK_EN
          if (slot_ok)                          fail_q <= '0;
          else if (fail_q != FAIL_W'(MAX_FAIL)) fail_q <= fail_q + FAIL_W'(1);
`endif
          state_q <= ST_RESP;
        end
        ST_RESP: begin
`ifdef EXIT_FAIL_LOCK_EN
          if (fail_q == FAIL_W'(MAX_FAIL)) begin
            timer_q  <= LOCK_W'(LOCK_CYCLES);
            locked_q <= 1'b1;
            state_q  <= ST_LOCK;
          end else begin
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end
`else
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
`endif
        end
`ifdef EXIT_FAIL_LOCK_EN
        ST_LOCK: begin
          if (timer_q == LOCK_W'(1)) begin
            timer_q  <= '0;
            locked_q <= 1'b0;
            fail_q   <= '0;
            ready_q  <= 1'b1;
            state_q  <= ST_IDLE;
          end else begin
            timer_q <= timer_q - LOCK_W'(1);
          end
        end
`endif
        default: begin
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign exit_ready  = ready_q;
  assign grant       = grant_q;
  assign deny        = deny_q;
  assign park_number = park_q;

endmodule

// File: tb/tb_exit_token_ctrl.sv
// Scoreboard bench for exit_token_ctrl: an 8-slot instance drives the main
// sequence, a 6-slot instance covers out-of-range slots.
module tb_exit_token_ctrl;

  typedef struct {
    logic        g;
    logic [2:0]  pn;
    int unsigned cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  exp_t        sb[$];

  // 8-slot instance
  logic       entry_valid = 1'b0, exit_req = 1'b0;
  logic [2:0] entry_slot = '0, token = '0, pattern = '0;
  logic       entry_err, exit_ready, grant, deny, locked;
  logic [2:0] park_number;
  logic [7:0] occupancy;
  logic [3:0] free_count;

  exit_token_ctrl #(.SLOT_W(3), .N_SLOTS(8), .MAX_FAIL(3), .LOCK_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .entry_valid(entry_valid), .entry_slot(entry_slot),
    .entry_err(entry_err), .exit_req(exit_req), .exit_ready(exit_ready),
    .token(token), .pattern(pattern), .grant(grant), .deny(deny),
    .park_number(park_number), .locked(locked), .occupancy(occupancy),
    .free_count(free_count)
  );

  // 6-slot instance
  logic       e6_valid = 1'b0, x6_req = 1'b0;
  logic [2:0] e6_slot = '0, tok6 = '0, pat6 = '0;
  logic       e6_err, x6_ready, grant6, deny6, locked6;
  logic [2:0] pn6;
  logic [5:0] occ6;
  logic [2:0] free6;

  exit_token_ctrl #(.SLOT_W(3), .N_SLOTS(6), .MAX_FAIL(3), .LOCK_CYCLES(16)) dut6 (
    .clk(clk), .rst(rst), .entry_valid(e6_valid), .entry_slot(e6_slot),
    .entry_err(e6_err), .exit_req(x6_req), .exit_ready(x6_ready),
    .token(tok6), .pattern(pat6), .grant(grant6), .deny(deny6),
    .park_number(pn6), .locked(locked6), .occupancy(occ6), .free_count(free6)
  );

  logic [7:0]  occ_m;
  int unsigned free_m;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Monitor: pops expected responses whenever the DUT pulses grant/deny
  always @(negedge clk) begin
    if (!rst) begin
      if (grant || deny) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_resp: got grant=%0b deny=%0b with nothing outstanding", grant, deny);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("resp_grant", {31'b0, grant}, {31'b0, e.g});
          chk("resp_deny", {31'b0, deny}, {31'b0, !e.g});
          chk("resp_park_number", {29'b0, park_number}, {29'b0, e.pn});
          chk("resp_cycle", cyc, e.cyc);
        end
      end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
        vectors++;
        miscompares++;
        $display("FAIL missing_resp: got none expected response due at cycle %0d", sb[0].cyc);
        void'(sb.pop_front());
      end
    end
  end

  task automatic chk_table();
    chk("occupancy", {24'b0, occupancy}, {24'b0, occ_m});
    chk("free_count", {28'b0, free_count}, free_m);
  endtask

  task automatic entry8(input logic [2:0] s);
    logic exp_err;
    step();
    entry_valid = 1'b1;
    entry_slot  = s;
    exp_err = occ_m[s];
    if (!occ_m[s]) begin
      occ_m[s] = 1'b1;
      free_m--;
    end
    step();
    entry_valid = 1'b0;
    chk("entry_err", {31'b0, entry_err}, {31'b0, exp_err});
    chk_table();
  endtask

  // Accepted at the end of cycle k; returns at the negedge of cycle k+1
  task automatic issue_exit(input logic [2:0] tk, input logic [2:0] pt, output int unsigned k);
    exp_t        e;
    logic [2:0]  s;
    step();
    exit_req = 1'b1;
    token    = tk;
    pattern  = pt;
    k = cyc;
    s = tk ^ pt;
    e.g   = occ_m[s];
    e.pn  = s;
    e.cyc = k + 2;
    sb.push_back(e);
    if (e.g) begin
      occ_m[s] = 1'b0;
      free_m++;
    end
    step();
    exit_req = 1'b0;
  endtask

  task automatic do_exit(input logic [2:0] tk, input logic [2:0] pt);
    int unsigned k;
    issue_exit(tk, pt, k);
    step();
    step();
    chk("exit_ready_back", {31'b0, exit_ready}, 32'd1);
    chk_table();
  endtask

  // Entry pulse during the decode cycle of an exit
  task automatic overlap_exit(input logic [2:0] tk, input logic [2:0] pt, input logic [2:0] es);
    int unsigned k;
    logic        exp_err;
    issue_exit(tk, pt, k);
    entry_valid = 1'b1;
    entry_slot  = es;
    exp_err = occ_m[es];
    if (!occ_m[es]) begin
      occ_m[es] = 1'b1;
      free_m--;
    end
    step();
    entry_valid = 1'b0;
    chk("overlap_entry_err", {31'b0, entry_err}, {31'b0, exp_err});
    step();
    chk_table();
  endtask

  initial begin
    int unsigned k;
    occ_m  = '0;
    free_m = 8;
    repeat (3) step();
    rst = 1'b0;
    step();

    chk("rst_occupancy", {24'b0, occupancy}, 32'd0);
    chk("rst_free_count", {28'b0, free_count}, 32'd8);
    chk("rst_park_number", {29'b0, park_number}, 32'd0);
    chk("rst_exit_ready", {31'b0, exit_ready}, 32'd1);
    chk("rst_outputs", {28'b0, grant, deny, entry_err, locked}, 32'd0);
    chk("rst_free6", {29'b0, free6}, 32'd6);

    // Entries 2,5 then token 110 ^ pattern 100 = slot 2 -> grant
    entry8(3'd2);
    entry8(3'd5);
    do_exit(3'b110, 3'b100);
    chk("t1_occupancy", {24'b0, occupancy}, 32'h20);
    chk("t1_free_count", {28'b0, free_count}, 32'd7);

    // Free slot 1 -> deny, table unchanged
    do_exit(3'b001, 3'b000);

    // Entry to an occupied slot is rejected
    entry8(3'd4);
    entry8(3'd4);

    // Same-slot overlap: slot 4 leaves and re-enters in the same window
    overlap_exit(3'b100, 3'b000, 3'd4);
    chk("same_slot_occ4", {31'b0, occupancy[4]}, 32'd1);
    chk("same_slot_free", {28'b0, free_count}, 32'd6);
    // Different-slot overlap: slot 5 leaves, slot 3 enters
    overlap_exit(3'b101, 3'b000, 3'd3);

    // 6-slot instance: out-of-range entry and exit
    step();
    e6_valid = 1'b1;
    e6_slot  = 3'd7;
    step();
    e6_valid = 1'b0;
    chk("n6_entry_err", {31'b0, e6_err}, 32'd1);
    chk("n6_occupancy", {26'b0, occ6}, 32'd0);
    chk("n6_free", {29'b0, free6}, 32'd6);
    step();
    x6_req = 1'b1;
    tok6   = 3'b010;
    pat6   = 3'b101;
    step();
    x6_req = 1'b0;
    step();
    chk("n6_deny", {30'b0, grant6, deny6}, 32'd1);
    chk("n6_park_number", {29'b0, pn6}, 32'd7);

    // Three consecutive denials
    do_exit(3'b000, 3'b000);
    do_exit(3'b001, 3'b000);
    issue_exit(3'b111, 3'b101, k);
    step();
    step();
`ifdef EXIT_FAIL_LOCK_EN
    chk("lock_start_locked", {31'b0, locked}, 32'd1);
    chk("lock_start_ready", {31'b0, exit_ready}, 32'd0);
    entry8(3'd6);
    step();
    exit_req = 1'b1;
    token    = 3'b100;
    pattern  = 3'b000;
    step();
    exit_req = 1'b0;
    while (cyc < k + 18) step();
    chk("lock_end_locked", {31'b0, locked}, 32'd1);
    chk("lock_end_ready", {31'b0, exit_ready}, 32'd0);
    step();
    chk("lock_release_locked", {31'b0, locked}, 32'd0);
    chk("lock_release_ready", {31'b0, exit_ready}, 32'd1);
`else
    chk("nolock_locked", {31'b0, locked}, 32'd0);
    chk("nolock_ready", {31'b0, exit_ready}, 32'd1);
    entry8(3'd6);
`endif
    do_exit(3'b011, 3'b101);

    // Reset during decode drops the request and clears the table
    issue_exit(3'b100, 3'b000, k);
    rst = 1'b1;
    sb.delete();
    occ_m  = '0;
    free_m = 8;
    step();
    rst = 1'b0;
    chk("midrst_ready", {31'b0, exit_ready}, 32'd1);
    chk("midrst_resp", {30'b0, grant, deny}, 32'd0);
    chk_table();
    step();
    chk("midrst_resp_after", {30'b0, grant, deny}, 32'd0);
    step();
    chk("sb_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "timeout");
  end

endmodule
